// File: rtl/serial_frame_receiver_pkg.sv
// Frame format constants and FSM encodings shared by both ends of the tracker serial link.
package serial_frame_receiver_pkg;

  localparam logic [7:0] HEADER_BYTE         = 8'hA5;
  localparam int         FRAME_PAYLOAD_BYTES = 6;
  localparam int         PAD_BITS            = 7;
  localparam int         DECODED_W           = 17;
  localparam int         TIMESTAMP_W         = 24;
  localparam int         PAYLOAD_W           = 8 * FRAME_PAYLOAD_BYTES;
  localparam int         DEF_CLKS_PER_BIT    = 104;
  localparam int         DEF_TIMEOUT_CLKS    = 2080;

  localparam logic [1:0] BYTE_IDLE  = 2'd0;
  localparam logic [1:0] BYTE_START = 2'd1;
  localparam logic [1:0] BYTE_DATA  = 2'd2;
  localparam logic [1:0] BYTE_STOP  = 2'd3;

  localparam logic [0:0] FRAME_HUNT    = 1'b0;
  localparam logic [0:0] FRAME_PAYLOAD = 1'b1;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Serial line in and decoded frame out; master is the receiver, slave is its consumer.
interface serial_frame_receiver_if;
  import serial_frame_receiver_pkg::*;

  logic                   rx;
  logic                   data_valid;
  logic [DECODED_W-1:0]   decoded_data;
  logic [TIMESTAMP_W-1:0] timestamp_last_data;
  logic                   frame_error;

  modport master (input rx, output data_valid, decoded_data, timestamp_last_data, frame_error);
  modport slave  (output rx, input data_valid, decoded_data, timestamp_last_data, frame_error);
endinterface

// File: rtl/serial_frame_receiver_uart_rx_byte.sv
// 8N1 byte deserialiser with rx synchroniser; byte_ok/stop_err pulse on the stop-bit sample cycle.
//   state      | meaning
//   BYTE_IDLE  | waiting for high->low edge on synced rx
//   BYTE_START | half-bit wait, then confirm start bit is still low
//   BYTE_DATA  | sampling 8 data bits at bit centres, LSB first
//   BYTE_STOP  | sampling the stop bit
module uart_rx_byte
  import serial_frame_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk_12MHz,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       stop_err
);

  localparam int            TW          = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta, rx_sync, rx_prev;
  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tick;

  assign tick = (timer == '0);

  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      state   <= BYTE_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        BYTE_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= BYTE_START;
            timer <= HALF_RELOAD;
          end
        end
        BYTE_START: begin
          if (tick) begin
            if (rx_sync) begin
              state <= BYTE_IDLE;
            end else begin
              state   <= BYTE_DATA;
              timer   <= BIT_RELOAD;
              bit_idx <= '0;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        BYTE_DATA: begin
          if (tick) begin
            shift <= {rx_sync, shift[7:1]};
            timer <= BIT_RELOAD;
            if (bit_idx == 3'd7) state <= BYTE_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        BYTE_STOP: begin
          // Leave immediately so a start edge right after the stop bit is caught.
          if (tick) state <= BYTE_IDLE;
          else      timer <= timer - TW'(1);
        end
        default: state <= BYTE_IDLE;
      endcase
    end
  end

  assign rx_byte  = shift;
  assign byte_ok  = (state == BYTE_STOP) && tick && rx_sync;
  assign stop_err = (state == BYTE_STOP) && tick && !rx_sync;

endmodule

// File: rtl/serial_frame_receiver.sv
// Frame reassembly: header hunt, 6-byte payload collection, inter-byte timeout and output latch.
//   state         | meaning
//   FRAME_HUNT    | discarding bytes until HEADER_BYTE arrives
//   FRAME_PAYLOAD | collecting payload bytes 0..5, MSB byte first
module serial_frame_receiver #(
  parameter int         CLKS_PER_BIT = serial_frame_receiver_pkg::DEF_CLKS_PER_BIT,
  parameter logic [7:0] HEADER_BYTE  = serial_frame_receiver_pkg::HEADER_BYTE,
  parameter int         TIMEOUT_CLKS = serial_frame_receiver_pkg::DEF_TIMEOUT_CLKS
) (
  input logic                     clk_12MHz,
  input logic                     reset,
  serial_frame_receiver_if.master bus
);
  import serial_frame_receiver_pkg::*;

  localparam int             TOW            = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TOW-1:0] TIMEOUT_RELOAD = TOW'(TIMEOUT_CLKS - 1);
  localparam logic [2:0]     LAST_IDX       = 3'(FRAME_PAYLOAD_BYTES - 1);

  logic [7:0]             rx_byte;
  logic                   byte_ok, stop_err;
  logic [0:0]             state;
  logic [2:0]             byte_idx;
  logic [PAYLOAD_W-9:0]   shift;
  logic [PAYLOAD_W-1:0]   next_word;
  logic [TOW-1:0]         idle_cnt;
  logic                   data_valid_q, frame_error_q;
  logic [DECODED_W-1:0]   decoded_q;
  logic [TIMESTAMP_W-1:0] timestamp_q;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_byte (
    .clk_12MHz (clk_12MHz),
    .reset     (reset),
    .rx        (bus.rx),
    .rx_byte   (rx_byte),
    .byte_ok   (byte_ok),
    .stop_err  (stop_err)
  );

  assign next_word = {shift, rx_byte};

  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      state         <= FRAME_HUNT;
      byte_idx      <= '0;
      shift         <= '0;
      idle_cnt      <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      decoded_q     <= '0;
      timestamp_q   <= '0;
    end else begin
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      case (state)
        FRAME_HUNT: begin
          if (byte_ok && (rx_byte == HEADER_BYTE)) begin
            state    <= FRAME_PAYLOAD;
            byte_idx <= '0;
            shift    <= '0;
            idle_cnt <= TIMEOUT_RELOAD;
          end
        end
        FRAME_PAYLOAD: begin
          if (byte_ok) begin
            shift    <= next_word[PAYLOAD_W-9:0];
            idle_cnt <= TIMEOUT_RELOAD;
            if (byte_idx == LAST_IDX) begin
              state <= FRAME_HUNT;
              if (next_word[PAYLOAD_W-1 -: PAD_BITS] != '0) begin
                frame_error_q <= 1'b1;
              end else begin
                data_valid_q <= 1'b1;
                decoded_q    <= next_word[TIMESTAMP_W +: DECODED_W];
                timestamp_q  <= next_word[TIMESTAMP_W-1:0];
              end
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end else if (stop_err || (idle_cnt == '0)) begin
            frame_error_q <= 1'b1;
            state         <= FRAME_HUNT;
          end else begin
            idle_cnt <= idle_cnt - TOW'(1);
          end
        end
        default: state <= FRAME_HUNT;
      endcase
    end
  end

  assign bus.data_valid          = data_valid_q;
  assign bus.frame_error         = frame_error_q;
  assign bus.decoded_data        = decoded_q;
  assign bus.timestamp_last_data = timestamp_q;

endmodule
